iob_bus_arbiter: RTL and testbench

- Shares one native memory bus between N requesters: the PicoRV32 instruction and data buses, plus optional DMA/debug masters.
- Sits between the CPU wrapper's ibus/dbus outputs and a single-port memory or peripheral interconnect.
- Round-robin arbitration; grant is held for exactly one transaction (valid-to-ready).
- A watchdog timeout completes any transaction the slave never acknowledges.

---
 rtl/iob_bus_arbiter_pkg.sv | 19 +
 rtl/iob_rr_select.sv | 26 ++
 rtl/iob_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_iob_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_bus_arbiter_pkg.sv
// Shared types and bus-format width helpers for the native memory bus arbiter.
// Request layout  : {valid, address, wdata, wstrb}  (valid is the MSB)
// Response layout : {rdata, ready}                 (ready is the LSB)
package iob_bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int iob_req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int iob_resp_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/iob_rr_select.sv
// Round-robin winner select: first asserted request scanning from i_ptr upward,
// wrapping modulo N. Purely combinational so it can be reused by other arbiters.
module iob_rr_select #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int PW = $clog2(N);

    // Scan from the farthest candidate back to i_ptr so the closest request wins.
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_idx = PW'((int'(i_ptr) + k) % N);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/iob_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus between N masters.
// A grant lasts exactly one valid-to-ready transaction; a watchdog completes
// transactions the slave never acknowledges.
//
// state | meaning
// IDLE  | no grant; slave request idle, slave ready ignored; arbitrate on valid
// BUSY  | master r_grant owns the slave until ready or watchdog expiry
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [N_MASTERS*iob_req_w(ADDR_W, DATA_W)-1:0]   m_req,
    output logic [N_MASTERS*iob_resp_w(DATA_W)-1:0]          m_resp,
    output logic [iob_req_w(ADDR_W, DATA_W)-1:0]             s_req,
    input  logic [iob_resp_w(DATA_W)-1:0]                    s_resp,
    output logic                                             busy,
    output logic                                             timeout
);

    localparam int REQ_W  = iob_req_w(ADDR_W, DATA_W);
    localparam int RESP_W = iob_resp_w(DATA_W);
    localparam int GW     = $clog2(N_MASTERS);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_rr_ptr;
    logic [TIMEOUT_W-1:0] r_wd_cnt;

    logic [REQ_W-1:0]     w_req_arr [N_MASTERS];
    logic [N_MASTERS-1:0] w_valid;
    logic [REQ_W-1:0]     w_granted_req;
    logic [RESP_W-1:0]    w_resp_slice;
    logic [GW-1:0]        w_win_idx;
    logic [GW-1:0]        w_grant_next;
    logic                 w_any_req;
    logic                 w_s_ready;
    logic                 w_wd_full;
    logic                 w_done;

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign w_req_arr[gi] = m_req[gi*REQ_W +: REQ_W];
            assign w_valid[gi]   = m_req[gi*REQ_W + REQ_W - 1];
        end
    endgenerate

    iob_rr_select #(
        .N (N_MASTERS)
    ) u_rr_select (
        .i_req (w_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_win_idx),
        .o_any (w_any_req)
    );

    assign w_granted_req = w_req_arr[r_grant];
    assign w_s_ready     = s_resp[0];
    assign w_wd_full     = &r_wd_cnt;
    assign w_grant_next  = (r_grant == GW'(N_MASTERS - 1)) ? '0 : r_grant + GW'(1);
    assign busy          = (r_state == BUSY);

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, slave request and response routing to the granted master only.
    always_comb begin
        w_state_nxt  = r_state;
        s_req        = '0;
        w_resp_slice = '0;
        timeout      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_s_ready) begin
                    s_req        = w_granted_req;
                    w_resp_slice = s_resp;
                    w_done       = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_wd_full) begin
                    // Watchdog completion: fake a ready with zero data, withdraw the request.
                    w_resp_slice = RESP_W'(1);
                    timeout      = 1'b1;
                    w_done       = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    s_req = w_granted_req;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (GW'(i) == r_grant) begin
                m_resp[i*RESP_W +: RESP_W] = w_resp_slice;
            end
        end
    end

    // Grant capture, round-robin pointer advance and watchdog count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wd_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_any_req) begin
                r_grant  <= w_win_idx;
                r_wd_cnt <= '0;
            end
        end else if (w_done) begin
            r_rr_ptr <= w_grant_next;
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + TIMEOUT_W'(1);
        end
    end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Directed bench: two arbiter instances (2 and 3 masters, 4-bit watchdog).
module tb_iob_bus_arbiter;

    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic clk;
    logic rst2, rst3;

    logic [2*REQ_W-1:0]  m_req2;
    logic [2*RESP_W-1:0] m_resp2;
    logic [REQ_W-1:0]    s_req2;
    logic [RESP_W-1:0]   s_resp2;
    logic                busy2, timeout2;

    logic [3*REQ_W-1:0]  m_req3;
    logic [3*RESP_W-1:0] m_resp3;
    logic [REQ_W-1:0]    s_req3;
    logic [RESP_W-1:0]   s_resp3;
    logic                busy3, timeout3;

    int n_checks = 0;
    int n_errors = 0;

    iob_bus_arbiter #(
        .N_MASTERS (2), .ADDR_W (32), .DATA_W (32), .TIMEOUT_W (4)
    ) u_dut2 (
        .clk (clk), .rst (rst2), .m_req (m_req2), .m_resp (m_resp2),
        .s_req (s_req2), .s_resp (s_resp2), .busy (busy2), .timeout (timeout2)
    );

    iob_bus_arbiter #(
        .N_MASTERS (3), .ADDR_W (32), .DATA_W (32), .TIMEOUT_W (4)
    ) u_dut3 (
        .clk (clk), .rst (rst3), .m_req (m_req3), .m_resp (m_resp3),
        .s_req (s_req3), .s_resp (s_resp3), .busy (busy3), .timeout (timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] rd, input logic rdy);
        return {rd, rdy};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [REQ_W-1:0]  req_a, req_b, req_m2;
    logic [RESP_W-1:0] rsp;
    logic [2*RESP_W-1:0] exp_resp2;
    logic [REQ_W-1:0]  exp_sreq;

    initial begin
        rst2 = 1'b0; rst3 = 1'b0;
        m_req2 = '0; s_resp2 = '0;
        m_req3 = '0; s_resp3 = '0;
        #1;
        rst2 = 1'b1; rst3 = 1'b1;
        #1;
        check("rst_sreq",    s_req2,   '0);
        check("rst_mresp",   m_resp2,  '0);
        check("rst_busy",    busy2,    1'b0);
        check("rst_timeout", timeout2, 1'b0);
        step; step;
        rst2 = 1'b0; rst3 = 1'b0;

        // Single master read, slave ready on the third BUSY cycle
        step;
        req_a = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
        m_req2[REQ_W-1:0] = req_a;
        #1;
        check("t1_idle_sreq", s_req2, '0);
        check("t1_idle_busy", busy2, 1'b0);
        step;
        check("t1_b1_busy", busy2, 1'b1);
        check("t1_b1_sreq", s_req2, req_a);
        check("t1_b1_mresp", m_resp2, '0);
        step;
        check("t1_b2_busy", busy2, 1'b1);
        check("t1_b2_mresp", m_resp2, '0);
        step;
        s_resp2 = mk_resp(32'hDEADBEEF, 1'b1);
        #1;
        check("t1_b3_busy", busy2, 1'b1);
        check("t1_b3_resp0", m_resp2[RESP_W-1:0], mk_resp(32'hDEADBEEF, 1'b1));
        check("t1_b3_resp1", m_resp2[2*RESP_W-1:RESP_W], '0);
        step;
        m_req2 = '0; s_resp2 = '0;
        #1;
        check("t1_end_busy", busy2, 1'b0);
        check("t1_end_mresp", m_resp2, '0);

        // Write pass-through from master 1 (rr_ptr now 1)
        step;
        req_b = mk_req(1'b1, 32'h20, 32'h12345678, 4'hF);
        m_req2[2*REQ_W-1:REQ_W] = req_b;
        #1;
        check("t2_idle_sreq", s_req2, '0);
        step;
        check("t2_sreq", s_req2, req_b);
        check("t2_busy", busy2, 1'b1);
        check("t2_mresp_wait", m_resp2, '0);
        s_resp2 = mk_resp(32'h0, 1'b1);
        #1;
        check("t2_resp1", m_resp2[2*RESP_W-1:RESP_W], mk_resp(32'h0, 1'b1));
        check("t2_resp0", m_resp2[RESP_W-1:0], '0);
        step;
        m_req2 = '0; s_resp2 = '0;
        #1;
        check("t2_end_busy", busy2, 1'b0);

        // Both masters requesting, slave always ready: grants alternate 0,1,0,1
        step;
        req_a = mk_req(1'b1, 32'h1000, 32'h0, 4'h0);
        req_b = mk_req(1'b1, 32'h2000, 32'h0, 4'h0);
        m_req2 = {req_b, req_a};
        rsp = mk_resp(32'hA5A5A5A5, 1'b1);
        s_resp2 = rsp;
        #1;
        check("t3_idle_ready_ignored", m_resp2, '0);
        for (int t = 0; t < 8; t++) begin
            step;
            if (t % 2 == 1) begin
                exp_resp2 = '0;
                exp_sreq  = '0;
            end else if ((t / 2) % 2 == 0) begin
                exp_resp2 = {{RESP_W{1'b0}}, rsp};
                exp_sreq  = req_a;
            end else begin
                exp_resp2 = {rsp, {RESP_W{1'b0}}};
                exp_sreq  = req_b;
            end
            check($sformatf("t3_mresp_%0d", t), m_resp2, exp_resp2);
            check($sformatf("t3_sreq_%0d", t), s_req2, exp_sreq);
            check($sformatf("t3_busy_%0d", t), busy2, (t % 2 == 0));
        end
        m_req2 = '0; s_resp2 = '0;

        // Watchdog: master 1, slave never ready, expiry on the 16th BUSY cycle
        step;
        req_b = mk_req(1'b1, 32'h300, 32'h0, 4'h0);
        m_req2[2*REQ_W-1:REQ_W] = req_b;
        s_resp2 = mk_resp(32'hDEAD0000, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step;
            check($sformatf("t4_busy_%0d", k), busy2, 1'b1);
            check($sformatf("t4_to_%0d", k), timeout2, 1'b0);
            check($sformatf("t4_mresp_%0d", k), m_resp2, '0);
        end
        step;
        check("t4_fire_timeout", timeout2, 1'b1);
        check("t4_fire_mresp", m_resp2, {mk_resp(32'h0, 1'b1), {RESP_W{1'b0}}});
        check("t4_fire_sreq", s_req2, '0);
        check("t4_fire_busy", busy2, 1'b1);
        step;
        m_req2 = '0; s_resp2 = '0;
        #1;
        check("t4_after_timeout", timeout2, 1'b0);
        check("t4_after_busy", busy2, 1'b0);

        // Reset mid-transaction; rr_ptr must return to 0
        step;
        req_a = mk_req(1'b1, 32'h400, 32'h0, 4'h0);
        m_req2[REQ_W-1:0] = req_a;
        s_resp2 = mk_resp(32'h11, 1'b1);
        step;
        check("t5_pre_resp0", m_resp2[RESP_W-1:0], mk_resp(32'h11, 1'b1));
        step;
        req_b = mk_req(1'b1, 32'h500, 32'h0, 4'h0);
        m_req2 = {req_b, {REQ_W{1'b0}}};
        s_resp2 = '0;
        step;
        check("t5_grant1_sreq", s_req2, req_b);
        step;
        s_resp2 = mk_resp(32'h22, 1'b1);
        rst2 = 1'b1;
        #1;
        check("t5_rst_busy", busy2, 1'b0);
        check("t5_rst_sreq", s_req2, '0);
        check("t5_rst_mresp", m_resp2, '0);
        step;
        rst2 = 1'b0;
        req_a = mk_req(1'b1, 32'h600, 32'h0, 4'h0);
        m_req2 = {req_b, req_a};
        s_resp2 = '0;
        step;
        check("t5_post_sreq", s_req2, req_a);
        s_resp2 = mk_resp(32'h33, 1'b1);
        #1;
        check("t5_post_mresp", m_resp2, {{RESP_W{1'b0}}, mk_resp(32'h33, 1'b1)});
        step;
        m_req2 = '0; s_resp2 = '0;

        // Three masters, only master 2 requesting: consecutive grants to 2
        step;
        req_m2 = mk_req(1'b1, 32'h700, 32'hCAFE, 4'h3);
        m_req3[3*REQ_W-1:2*REQ_W] = req_m2;
        rsp = mk_resp(32'h00C0FFEE, 1'b1);
        s_resp3 = rsp;
        #1;
        check("t6_idle_mresp", m_resp3, '0);
        for (int t = 0; t < 6; t++) begin
            step;
            if (t % 2 == 0) begin
                check($sformatf("t6_busy_%0d", t), busy3, 1'b1);
                check($sformatf("t6_sreq_%0d", t), s_req3, req_m2);
                check($sformatf("t6_mresp_%0d", t), m_resp3, {rsp, {(2*RESP_W){1'b0}}});
            end else begin
                check($sformatf("t6_busy_%0d", t), busy3, 1'b0);
                check($sformatf("t6_mresp_%0d", t), m_resp3, '0);
            end
        end
        m_req3 = '0; s_resp3 = '0;
        step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
